// File: rtl/maxpool_reduce.sv
// Max-pooling reduction stage: aligns generator flags with read data, keeps a
// running signed maximum per patch and writes one pooled value per patch.
module maxpool_reduce #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 19,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              maxpool_enable,
   input  logic              patch_end,
   input  logic              maxpool_done,
   input  logic [DATA_W-1:0] rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_address,
   output logic [DATA_W-1:0] wr_data,
   output logic              pool_done,
   output logic              busy
);

   typedef struct packed {
      logic valid;
      logic pe;
      logic dn;
   } tag_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   tag_t [RD_LAT-1:0]       tag_q, tag_d;
   tag_t                    issue_tag;
   tag_t                    d_tag;
   logic                    maxpool_done_q;
   logic [DATA_W-1:0]       acc_q, acc_d;
   logic [ADDR_W-1:0]       cnt_q, cnt_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]       wr_address_q, wr_address_d;
   logic [DATA_W-1:0]       wr_data_q, wr_data_d;
   logic                    pool_done_q, pool_done_d;
   logic                    busy_q, busy_d;

   // Tag captured at address issue; the done flag is reduced to its rising edge.
   always_comb begin
      issue_tag       = '0;
      issue_tag.valid = maxpool_enable;
      issue_tag.pe    = patch_end;
      issue_tag.dn    = maxpool_done & ~maxpool_done_q;
   end

   if (RD_LAT == 1) begin : g_lat1
      assign tag_d = issue_tag;
   end else begin : g_latn
      assign tag_d = {tag_q[RD_LAT-2:0], issue_tag};
   end

   assign d_tag = tag_q[RD_LAT-1];

   // Next-state and datapath; d_dn has priority over d_pe so the last patch goes out via FLUSH.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      wr_en_d      = 1'b0;
      wr_address_d = wr_address_q;
      wr_data_d    = wr_data_q;
      pool_done_d  = 1'b0;
      busy_d       = busy_q;

      case (state_q)
         S_IDLE: begin
            if (d_tag.valid && !d_tag.dn) begin
               acc_d   = rd_data;
               busy_d  = 1'b1;
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (d_tag.valid) begin
               if (d_tag.dn) begin
                  state_d = S_FLUSH;
               end else if (d_tag.pe) begin
                  wr_en_d      = 1'b1;
                  wr_address_d = cnt_q;
                  wr_data_d    = acc_q;
                  cnt_d        = cnt_q + ADDR_W'(1);
                  acc_d        = rd_data;
               end else if ($signed(rd_data) > $signed(acc_q)) begin
                  acc_d = rd_data;
               end
            end
         end
         S_FLUSH: begin
            wr_en_d      = 1'b1;
            wr_address_d = cnt_q;
            wr_data_d    = acc_q;
            cnt_d        = cnt_q + ADDR_W'(1);
            state_d      = S_DONE;
         end
         S_DONE: begin
            // The flush strobe is only visible on the first DONE cycle, so it marks the pulse.
            if (wr_en_q) begin
               pool_done_d = 1'b1;
               busy_d      = 1'b0;
            end
            if (!maxpool_done) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         tag_q          <= '0;
         maxpool_done_q <= 1'b0;
         acc_q          <= '0;
         cnt_q          <= '0;
         wr_en_q        <= 1'b0;
         wr_address_q   <= '0;
         wr_data_q      <= '0;
         pool_done_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         tag_q          <= tag_d;
         maxpool_done_q <= maxpool_done;
         acc_q          <= acc_d;
         cnt_q          <= cnt_d;
         wr_en_q        <= wr_en_d;
         wr_address_q   <= wr_address_d;
         wr_data_q      <= wr_data_d;
         pool_done_q    <= pool_done_d;
         busy_q         <= busy_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_address = wr_address_q;
   assign wr_data    = wr_data_q;
   assign pool_done  = pool_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_maxpool_reduce.sv
// Scoreboard bench for maxpool_reduce: two instances (read latency 1 and 3)
// share one stimulus stream; a patch-level model predicts writes and their cycles.
module tb_maxpool_reduce;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 19;
   localparam int unsigned LAT_A  = 1;
   localparam int unsigned LAT_B  = 3;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int unsigned       cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              maxpool_enable = 1'b0;
   logic              patch_end = 1'b0;
   logic              maxpool_done = 1'b0;
   logic [DATA_W-1:0] pix = '0;
   logic [DATA_W-1:0] hist [4];
   logic [DATA_W-1:0] rd_a, rd_b;

   logic [1:0]        wr_en_w, pool_done_w, busy_w;
   logic [ADDR_W-1:0] wr_addr_w [2];
   logic [DATA_W-1:0] wr_data_w [2];

   int unsigned       cyc = 0;
   int unsigned       n_vec = 0;
   int unsigned       n_fail = 0;
   int unsigned       tie_cov = 0;

   exp_t              exp_q [2][$];
   int unsigned       done_q [2][$];

   // Patch-level reference model state
   logic [DATA_W-1:0] patch_px [$];
   logic              active = 1'b0;
   logic              prev_done = 1'b0;
   logic [ADDR_W-1:0] model_addr = '0;

   int stream_2x2 [8] = '{3, 7, -2, 5, 1, 1, 9, 0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Feature-map memory model: returns the pixel issued RD_LAT cycles earlier.
   always @(posedge clk) begin
      hist[0] <= pix;
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
   end
   assign rd_a = hist[LAT_A-1];
   assign rd_b = hist[LAT_B-1];

   maxpool_reduce #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(LAT_A)) u_dut_a (
      .clk(clk), .reset(reset), .maxpool_enable(maxpool_enable), .patch_end(patch_end),
      .maxpool_done(maxpool_done), .rd_data(rd_a), .wr_en(wr_en_w[0]),
      .wr_address(wr_addr_w[0]), .wr_data(wr_data_w[0]), .pool_done(pool_done_w[0]),
      .busy(busy_w[0])
   );

   maxpool_reduce #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(LAT_B)) u_dut_b (
      .clk(clk), .reset(reset), .maxpool_enable(maxpool_enable), .patch_end(patch_end),
      .maxpool_done(maxpool_done), .rd_data(rd_b), .wr_en(wr_en_w[1]),
      .wr_address(wr_addr_w[1]), .wr_data(wr_data_w[1]), .pool_done(pool_done_w[1]),
      .busy(busy_w[1])
   );

   function automatic int unsigned lat_of(input int d);
      return (d == 0) ? LAT_A : LAT_B;
   endfunction

   task automatic check(input string name, input int d, input logic [63:0] got,
                        input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s (lat%0d) cyc=%0d: got %0h, expected %0h", name, lat_of(d), cyc, got, want);
      end
   endtask

   // Monitor: compares whatever the DUTs present against the scoreboard queues.
   always @(negedge clk) begin
      exp_t        e;
      int unsigned dc;
      for (int d = 0; d < 2; d++) begin
         if (!reset) begin
            check("reset_outputs", d, 64'({wr_en_w[d], pool_done_w[d], busy_w[d],
                                           wr_addr_w[d], wr_data_w[d]}), 64'd0);
         end else begin
            if (wr_en_w[d]) begin
               if (exp_q[d].size() == 0) begin
                  check("unexpected_wr", d, 64'(wr_en_w[d]), 64'd0);
               end else begin
                  e = exp_q[d].pop_front();
                  check("wr_address", d, 64'(wr_addr_w[d]), 64'(e.addr));
                  check("wr_data", d, 64'(wr_data_w[d]), 64'(e.data));
                  check("wr_cycle", d, 64'(cyc), 64'(e.cyc));
                  check("busy_at_wr", d, 64'(busy_w[d]), 64'd1);
               end
            end
            if (pool_done_w[d]) begin
               if (done_q[d].size() == 0) begin
                  check("unexpected_done", d, 64'(pool_done_w[d]), 64'd0);
               end else begin
                  dc = done_q[d].pop_front();
                  check("done_cycle", d, 64'(cyc), 64'(dc));
                  check("busy_at_done", d, 64'(busy_w[d]), 64'd0);
               end
            end
         end
      end
   end

   // Close the current patch: its maximum goes to the next output address.
   task automatic close_patch(input int unsigned extra);
      logic [DATA_W-1:0] m;
      int                n_max;
      exp_t              e;
      m = patch_px[0];
      foreach (patch_px[i]) if ($signed(patch_px[i]) > $signed(m)) m = patch_px[i];
      n_max = 0;
      foreach (patch_px[i]) if (patch_px[i] == m) n_max++;
      if (n_max > 1) tie_cov++;
      for (int d = 0; d < 2; d++) begin
         e.addr = model_addr;
         e.data = m;
         e.cyc  = cyc + lat_of(d) + 1 + extra;
         exp_q[d].push_back(e);
      end
      model_addr = model_addr + ADDR_W'(1);
   endtask

   // Issue one generator cycle and advance the reference model.
   task automatic issue(input logic en, input logic pe, input logic dn, input logic [DATA_W-1:0] px);
      logic rise;
      @(posedge clk);
      #1;
      maxpool_enable = en;
      patch_end      = pe;
      maxpool_done   = dn;
      pix            = px;
      rise           = dn && !prev_done;
      prev_done      = dn;
      if (en) begin
         if (!active) begin
            if (!rise) begin
               active = 1'b1;
               patch_px.delete();
               patch_px.push_back(px);
            end
         end else if (rise) begin
            close_patch(1);
            for (int d = 0; d < 2; d++) done_q[d].push_back(cyc + lat_of(d) + 3);
            active     = 1'b0;
            model_addr = '0;
         end else if (pe) begin
            close_patch(0);
            patch_px.delete();
            patch_px.push_back(px);
         end else begin
            patch_px.push_back(px);
         end
      end
   endtask

   function automatic int unsigned pending();
      return exp_q[0].size() + exp_q[1].size() + done_q[0].size() + done_q[1].size();
   endfunction

   task automatic finish_layer(input logic pe, input logic [DATA_W-1:0] px);
      issue(1'b1, pe, 1'b1, px);
      for (int i = 0; i < 20 && pending() != 0; i++) issue(1'b0, 1'b0, 1'b1, DATA_W'($urandom));
      check("layer_drain", 0, 64'(pending()), 64'd0);
      issue(1'b0, 1'b0, 1'b0, DATA_W'($urandom));
      issue(1'b0, 1'b0, 1'b0, DATA_W'($urandom));
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < n; i++) begin
         maxpool_enable = 1'($urandom);
         patch_end      = 1'($urandom);
         maxpool_done   = 1'($urandom);
         pix            = DATA_W'($urandom);
         @(posedge clk);
         #1;
      end
      maxpool_enable = 1'b0;
      patch_end      = 1'b0;
      maxpool_done   = 1'b0;
      reset          = 1'b1;
      active         = 1'b0;
      prev_done      = 1'b0;
      model_addr     = '0;
      patch_px.delete();
   endtask

   task automatic gap();
      issue(1'b0, 1'($urandom), 1'b0, DATA_W'($urandom));
   endtask

   function automatic logic [DATA_W-1:0] rnd_px();
      int v;
      if ($urandom_range(0, 1) == 0) begin
         v = int'($urandom_range(0, 8)) - 4;
         return DATA_W'(v);
      end
      return DATA_W'($urandom);
   endfunction

   task automatic run_2x2();
      for (int i = 0; i < 8; i++) issue(1'b1, i == 4, 1'b0, DATA_W'(stream_2x2[i]));
      finish_layer(1'b0, 16'h0063);
   endtask

   task automatic random_layer();
      int np;
      int sz;
      np = $urandom_range(1, 5);
      for (int p = 0; p < np; p++) begin
         sz = $urandom_range(1, 4);
         for (int k = 0; k < sz; k++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) gap();
            issue(1'b1, (k == 0) ? ((p == 0) ? 1'($urandom) : 1'b1) : 1'b0, 1'b0, rnd_px());
         end
      end
      finish_layer(1'($urandom), rnd_px());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      do_reset(8);
      issue(1'b0, 1'b0, 1'b0, '0);

      run_2x2();

      // All-negative patch, then a tied patch closed with patch_end and done together.
      repeat (4) issue(1'b1, 1'b0, 1'b0, 16'hFFFC);
      issue(1'b1, 1'b1, 1'b0, 16'd5);
      issue(1'b1, 1'b0, 1'b0, 16'd5);
      finish_layer(1'b1, 16'h7FFF);

      // Enable gaps inside a patch.
      issue(1'b1, 1'b0, 1'b0, 16'd2);
      gap();
      gap();
      issue(1'b1, 1'b0, 1'b0, 16'd8);
      gap();
      issue(1'b1, 1'b0, 1'b0, 16'd6);
      issue(1'b1, 1'b1, 1'b0, 16'd1);
      finish_layer(1'b0, 16'd100);

      // Reset in the middle of a patch, then the reference stream again.
      issue(1'b1, 1'b0, 1'b0, 16'd3);
      issue(1'b1, 1'b0, 1'b0, 16'd7);
      do_reset(3);
      issue(1'b0, 1'b0, 1'b0, '0);
      run_2x2();

      for (int l = 0; l < 30; l++) random_layer();

      repeat (4) issue(1'b0, 1'b0, 1'b0, '0);
      check("final_drain", 0, 64'(pending()), 64'd0);
      $display("coverage: %0d patches with tied maxima", tie_cov);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
